// File: rtl/supernova_phys_free_list.sv
// Physical GPR free list for the Supernova rename stage: circular tag FIFO with speculative head, committed head and tail.
// Optional protocol checking (in_list vector, sticky err_o) is enabled by defining SUPERNOVA_FREELIST_CHECK_EN.
module supernova_phys_free_list #(
    parameter int RENAME_WIDTH  = 4,
    parameter int COMMIT_WIDTH  = 4,
    parameter int NUM_PHYS_GPRS = 128,
    parameter int NUM_ARCH_GPRS = 32,
    parameter int TAG_W         = $clog2(NUM_PHYS_GPRS),
    parameter int PTR_W         = TAG_W + 1,
    parameter int CNT_W         = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RENAME_WIDTH-1:0]         alloc_req_i,
    output logic                            alloc_gnt_o,
    output logic [RENAME_WIDTH*TAG_W-1:0]   alloc_tag_o,
    input  logic [COMMIT_WIDTH-1:0]         free_valid_i,
    input  logic [COMMIT_WIDTH*TAG_W-1:0]   free_tag_i,
    input  logic [CNT_W-1:0]                commit_alloc_cnt_i,
    input  logic                            flush_i,
    output logic [PTR_W-1:0]                free_count_o,
    output logic                            err_o
);

    logic [TAG_W-1:0] tags_q [NUM_PHYS_GPRS];
    logic [PTR_W-1:0] spec_head_q, spec_head_d;
    logic [PTR_W-1:0] cmt_head_q, cmt_head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] req_cnt, rel_cnt;
    logic [TAG_W-1:0] alloc_idx [RENAME_WIDTH];
    logic [TAG_W-1:0] free_idx [COMMIT_WIDTH];
    logic             gnt;

    assign free_count_o = tail_q - spec_head_q;
    assign gnt          = !flush_i && (req_cnt <= free_count_o);
    assign alloc_gnt_o  = gnt;

    // Requesting lanes are compacted in lane order onto consecutive FIFO slots; same for returned tags at the tail.
    always_comb begin
        req_cnt     = '0;
        rel_cnt     = '0;
        alloc_tag_o = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            alloc_idx[i] = TAG_W'(spec_head_q + req_cnt);
            alloc_tag_o[i*TAG_W +: TAG_W] = tags_q[alloc_idx[i]];
            if (alloc_req_i[i]) req_cnt = req_cnt + PTR_W'(1);
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            free_idx[i] = TAG_W'(tail_q + rel_cnt);
            if (free_valid_i[i]) rel_cnt = rel_cnt + PTR_W'(1);
        end
    end

    // Commit is applied before the flush restore, so the restore point includes this cycle's commits.
    always_comb begin
        cmt_head_d  = cmt_head_q + PTR_W'(commit_alloc_cnt_i);
        tail_d      = tail_q + rel_cnt;
        spec_head_d = spec_head_q;
        if (flush_i)  spec_head_d = cmt_head_d;
        else if (gnt) spec_head_d = spec_head_q + req_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= PTR_W'(NUM_PHYS_GPRS - NUM_ARCH_GPRS);
            for (int k = 0; k < NUM_PHYS_GPRS; k++) tags_q[k] <= TAG_W'(NUM_ARCH_GPRS + k);
        end else begin
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
            for (int i = 0; i < COMMIT_WIDTH; i++)
                if (free_valid_i[i]) tags_q[free_idx[i]] <= free_tag_i[i*TAG_W +: TAG_W];
        end
    end

`ifdef SUPERNOVA_FREELIST_CHECK_EN
    localparam int MAX_FREE = NUM_PHYS_GPRS - NUM_ARCH_GPRS;
    localparam logic [NUM_PHYS_GPRS-1:0] IN_LIST_RST = {{MAX_FREE{1'b1}}, {NUM_ARCH_GPRS{1'b0}}};

    logic [NUM_PHYS_GPRS-1:0] in_list_q, in_list_d;
    logic                     err_q, err_d;
    logic [PTR_W-1:0]         squash_cnt;
    logic [TAG_W-1:0]         walk_idx, ftag;

    always_comb begin
        in_list_d  = in_list_q;
        err_d      = err_q;
        squash_cnt = spec_head_q - cmt_head_d;
        walk_idx   = '0;
        ftag       = '0;
        if (gnt)
            for (int i = 0; i < RENAME_WIDTH; i++)
                if (alloc_req_i[i]) in_list_d[tags_q[alloc_idx[i]]] = 1'b0;
        // Squashed tags sit between the restored head and the old speculative head.
        if (flush_i)
            for (int j = 0; j < NUM_PHYS_GPRS; j++) begin
                walk_idx = cmt_head_d[TAG_W-1:0] + TAG_W'(j);
                if (PTR_W'(j) < squash_cnt) in_list_d[tags_q[walk_idx]] = 1'b1;
            end
        for (int i = 0; i < COMMIT_WIDTH; i++)
            if (free_valid_i[i]) begin
                ftag = free_tag_i[i*TAG_W +: TAG_W];
                if (in_list_d[ftag]) err_d = 1'b1;
                in_list_d[ftag] = 1'b1;
            end
        if ((tail_d - cmt_head_d) > PTR_W'(MAX_FREE)) err_d = 1'b1;
        if (PTR_W'(commit_alloc_cnt_i) > (spec_head_q - cmt_head_q)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_list_q <= IN_LIST_RST;
            err_q     <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
